// File: rtl/nol_seq_gen_101_tx.sv
// Serial stimulus transmitter for a non-overlapping "101" Mealy detector.
// Parallel words come in over a valid/ready handshake and leave one bit per
// clock on `out`. An embedded reference model watches the same stream and
// produces the expected detect flag plus a saturating detection count.
module nol_seq_gen_101_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             out,
    output logic             out_valid,
    output logic             exp_det,
    output logic [CNT_W-1:0] det_count,
    input  logic             det_clr,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);

    // Transmit FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Reference model encoding
    localparam logic [1:0] R_S0  = 2'd0;
    localparam logic [1:0] R_S1  = 2'd1;
    localparam logic [1:0] R_S10 = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [1:0]       ref_q,   ref_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic last_bit;
    logic accept;
    logic cur_bit;

    // The current bit always sits at the outgoing end of the shift register.
    assign cur_bit    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign out_valid  = (state_q == ST_SHIFT);
    assign busy       = out_valid;
    assign out        = out_valid & cur_bit;
    assign last_bit   = out_valid && (idx_q == LAST_IDX);
    // Ready on the last bit lets a new word follow with no gap.
    assign load_ready = (state_q == ST_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;
    assign exp_det    = out_valid && out && (ref_q == R_S10);
    assign det_count  = cnt_q;

    // Transmit FSM next state: load on acceptance, otherwise shift or retire.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = load_data;
            idx_d   = '0;
        end else if (state_q == ST_SHIFT) begin
            if (last_bit) begin
                state_d = ST_IDLE;
                shreg_d = '0;
                idx_d   = '0;
            end else begin
                shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
                idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

    // Reference model next state: any stream gap drops a partial match.
    always_comb begin
        ref_d = R_S0;
        if (out_valid) begin
            case (ref_q)
                R_S0:    ref_d = out ? R_S1 : R_S0;
                R_S1:    ref_d = out ? R_S1 : R_S10;
                R_S10:   ref_d = R_S0;  // a completing 1 is consumed
                default: ref_d = R_S0;
            endcase
        end
    end

    // Detection counter: clear wins over increment, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (det_clr) begin
            cnt_d = '0;
        end else if (exp_det && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            ref_q   <= R_S0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nol_seq_gen_101_tx.sv
// Bench for nol_seq_gen_101_tx: table of single-word vectors plus
// hand-written sequences for streaming, back-pressure, reset and saturation.
module tb_nol_seq_gen_101_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             out;
    logic             out_valid;
    logic             exp_det;
    logic [CNT_W-1:0] det_count;
    logic             det_clr;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    nol_seq_gen_101_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out        (out),
        .out_valid  (out_valid),
        .exp_det    (exp_det),
        .det_count  (det_count),
        .det_clr    (det_clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] det_mask;   // bit i = expected exp_det on transmitted bit i
        int         count;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".out_valid"},  32'(out_valid),  32'd0);
        chk({tag, ".out"},        32'(out),        32'd0);
        chk({tag, ".busy"},       32'(busy),       32'd0);
        chk({tag, ".load_ready"}, 32'(load_ready), 32'd1);
        chk({tag, ".exp_det"},    32'(exp_det),    32'd0);
    endtask

    // Send one word from IDLE (with junk on load_data while busy) and check
    // every bit; clr_idx >= 0 pulses det_clr during that bit.
    task automatic run_word(input logic [7:0] w, input logic [7:0] mask, input int clr_idx);
        load_data  = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("out",        32'(out),        32'(w[7-i]));
            chk("out_valid",  32'(out_valid),  32'd1);
            chk("busy",       32'(busy),       32'd1);
            chk("exp_det",    32'(exp_det),    32'(mask[i]));
            chk("load_ready", 32'(load_ready), 32'(i == 7));
            load_data = 8'($urandom);
            if (i == clr_idx) det_clr = 1'b1;
            tick();
            det_clr = 1'b0;
        end
        chk("post.out_valid", 32'(out_valid), 32'd0);
        chk("post.out",       32'(out),       32'd0);
    endtask

    initial begin
        logic [15:0] stream;
        logic [15:0] bmask;

        vecs[0] = '{8'b10100101, 8'b1000_0100, 2};
        vecs[1] = '{8'b10101000, 8'b0000_0100, 1};
        vecs[2] = '{8'b01011010, 8'b0100_1000, 2};
        vecs[3] = '{8'b11111111, 8'b0000_0000, 0};
        vecs[4] = '{8'b00000000, 8'b0000_0000, 0};

        rst = 1'b1; load_valid = 1'b0; load_data = '0; det_clr = 1'b0;

        // Reset values, during and after reset
        tick();
        chk_idle("rst");
        chk("rst.det_count", 32'(det_count), 32'd0);
        rst = 1'b0;
        tick();
        chk_idle("rel");
        chk("rel.det_count", 32'(det_count), 32'd0);

        // Table-driven single words
        foreach (vecs[k]) begin
            do_reset();
            run_word(vecs[k].data, vecs[k].det_mask, -1);
            chk("vec.det_count", 32'(det_count), 32'(vecs[k].count));
        end

        // Back-to-back with back-pressure: junk offered during A, B on last bit
        do_reset();
        stream = 16'b00000010_10000000;
        bmask  = 16'h0100;   // detect at global bit 8
        load_data  = 8'b00000010;
        load_valid = 1'b1;
        tick();
        for (int g = 0; g < 16; g++) begin
            chk("b2b.out",        32'(out),        32'(stream[15-g]));
            chk("b2b.out_valid",  32'(out_valid),  32'd1);
            chk("b2b.exp_det",    32'(exp_det),    32'(bmask[g]));
            chk("b2b.load_ready", 32'(load_ready), 32'((g == 7) || (g == 15)));
            if (g < 7)       load_data = 8'($urandom) | 8'h01;
            else if (g == 7) load_data = 8'b10000000;
            else             begin load_valid = 1'b0; load_data = 8'hFF; end
            tick();
        end
        chk("b2b.end_valid", 32'(out_valid), 32'd0);
        chk("b2b.det_count", 32'(det_count), 32'd1);

        // Same words with a one-cycle gap: no detection across the gap
        do_reset();
        run_word(8'b00000010, 8'h00, -1);
        run_word(8'b10000000, 8'h00, -1);
        chk("gap.det_count", 32'(det_count), 32'd0);

        // Reset mid-word aborts immediately and clears the count
        do_reset();
        run_word(8'b10100101, 8'b1000_0100, -1);
        chk("pre.det_count", 32'(det_count), 32'd2);
        load_data  = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        chk("mid.out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle("mid");
        chk("mid.det_count", 32'(det_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_idle("midrel");
        run_word(8'b10100101, 8'b1000_0100, -1);
        chk("after.det_count", 32'(det_count), 32'd2);

        // Saturation at 3, then clear coinciding with a detect
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            run_word(8'b10100000, 8'b0000_0100, -1);
            chk("sat.det_count", 32'(det_count), 32'((n < 3) ? n : 3));
        end
        run_word(8'b10100000, 8'b0000_0100, 2);
        chk("clr.det_count", 32'(det_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
